// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the microprocessor core.
// Loads 32-bit program words (two 16-bit halves, hi first) into instruction memory, holds the
// core in reset while loading, and gates core advance through cpu_en (RUN, single STEP, PAUSE).
// Optional feature macro: CPU_RUN_CTRL_BREAKPOINT_EN adds a PC breakpoint (bp_en/bp_addr/bp_hit).
module cpu_run_ctrl #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic              cpu_halted,
  input  logic [ADDR_W-1:0] cpu_pc,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [2:0]        state,
  output logic [15:0]       cyc_cnt,
  output logic              cmd_err,
  output logic              ld_ovf
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StStep  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpRun  = 2'b01;
  localparam logic [1:0] OpStep = 2'b10;
  localparam logic [1:0] OpHalt = 2'b11;

  // load_ptr needs one extra bit so it can hold IMEM_DEPTH itself (the overflow marker)
  localparam int unsigned PtrW = ADDR_W + 1;
  localparam logic [PtrW-1:0] DepthPtr = PtrW'(IMEM_DEPTH);

  state_e              state_q, state_d;
  logic                cmd_ready_q;
  logic                cpu_rst_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic [15:0]         cyc_cnt_q;
  logic                cmd_err_q;
  logic                ld_ovf_q;
  logic [PtrW-1:0]     load_ptr_q;
  logic                half_lo_q;
  logic [15:0]         hi_q;

  logic fire;
  logic load_ok, run_ok, step_ok, err_set;
  logic run_en;
  logic bp_gate;

  assign fire   = cmd_valid && cmd_ready_q;
  assign run_en = (state_q == StRun) || (state_q == StStep);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic first_run_q;
  logic bp_hit_q;

  // Breakpoint only stalls free-running RUN, and never on the first cycle after a resume
  assign bp_gate = bp_en && (state_q == StRun) && !first_run_q && (cpu_pc == bp_addr);
  assign bp_hit  = bp_hit_q;
`else
  logic unused_pc;

  assign unused_pc = ^cpu_pc;
  assign bp_gate   = 1'b0;
`endif

  assign cpu_en = run_en && !bp_gate;

  // Next-state decode and command classification
  always_comb begin
    state_d = state_q;
    load_ok = 1'b0;
    run_ok  = 1'b0;
    step_ok = 1'b0;
    err_set = 1'b0;
    case (state_q)
      StIdle, StPause: begin
        if (fire) begin
          case (cmd_op)
            OpLoad: begin
              load_ok = 1'b1;
              state_d = StIdle;
            end
            OpRun: begin
              run_ok  = 1'b1;
              state_d = StRun;
            end
            OpStep: begin
              step_ok = 1'b1;
              state_d = StStep;
            end
            default: ;  // HALT is a no-op here
          endcase
        end
      end
      StDone: begin
        if (fire) begin
          if (cmd_op == OpLoad) begin
            load_ok = 1'b1;
            state_d = StIdle;
          end else if (cmd_op != OpHalt) begin
            err_set = 1'b1;
          end
        end
      end
      StRun: begin
        if (fire) begin
          if (cmd_op == OpHalt) begin
            state_d = StPause;
          end else begin
            err_set = 1'b1;
          end
        end
        if (bp_gate) begin
          state_d = StPause;
        end
        // Core halt wins over HALT command and breakpoint
        if (cpu_halted) begin
          state_d = StDone;
        end
      end
      StStep: begin
        state_d = cpu_halted ? StDone : StPause;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      cpu_rst_q   <= 1'b1;
      cmd_err_q   <= 1'b0;
      cyc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d != StStep);
      cpu_rst_q   <= (state_d == StIdle);
      if (err_set) begin
        cmd_err_q <= 1'b1;
      end
      if ((state_d == StIdle) && (state_q != StIdle)) begin
        cyc_cnt_q <= '0;
      end else if (cpu_en && (cyc_cnt_q != 16'hFFFF)) begin
        cyc_cnt_q <= cyc_cnt_q + 16'd1;
      end
    end
  end

  // Program loader: pairs halves into words and writes them sequentially
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      ld_ovf_q     <= 1'b0;
      load_ptr_q   <= '0;
      half_lo_q    <= 1'b0;
      hi_q         <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (load_ok) begin
        if (!half_lo_q) begin
          hi_q      <= cmd_data;
          half_lo_q <= 1'b1;
        end else begin
          half_lo_q <= 1'b0;
          if (load_ptr_q < DepthPtr) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= load_ptr_q[ADDR_W-1:0];
            imem_wdata_q <= {hi_q, cmd_data};
            load_ptr_q   <= load_ptr_q + PtrW'(1);
          end else begin
            ld_ovf_q <= 1'b1;
          end
        end
      end
      if (run_ok) begin
        ld_ovf_q <= 1'b0;
        if (state_q == StIdle) begin
          load_ptr_q <= '0;
          half_lo_q  <= 1'b0;
        end
      end
    end
  end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  // Breakpoint bookkeeping: resume marker and sticky hit flag
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      first_run_q <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      first_run_q <= run_ok;
      if (run_ok || step_ok) begin
        bp_hit_q <= 1'b0;
      end else if (bp_gate) begin
        bp_hit_q <= 1'b1;
      end
    end
  end
`endif

  assign state      = state_q;
  assign cmd_ready  = cmd_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cyc_cnt    = cyc_cnt_q;
  assign cmd_err    = cmd_err_q;
  assign ld_ovf     = ld_ovf_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl.
// Build with CPU_RUN_CTRL_BREAKPOINT_EN defined to also exercise the breakpoint feature.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        cpu_en;
  logic        cpu_halted;
  logic [3:0]  cpu_pc;
  logic [2:0]  state;
  logic [15:0] cyc_cnt;
  logic        cmd_err;
  logic        ld_ovf;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic        bp_en;
  logic [3:0]  bp_addr;
  logic        bp_hit;
`endif

  int errs   = 0;
  int checks = 0;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpRun  = 2'b01;
  localparam logic [1:0] OpStep = 2'b10;
  localparam logic [1:0] OpHalt = 2'b11;

  cpu_run_ctrl #(
    .IMEM_DEPTH (16),
    .ADDR_W     (4)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .cpu_halted (cpu_halted),
    .cpu_pc     (cpu_pc),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit),
`endif
    .state      (state),
    .cyc_cnt    (cyc_cnt),
    .cmd_err    (cmd_err),
    .ld_ovf     (ld_ovf)
  );

  always #5 clk = ~clk;

  // Stand-in core: PC held at 0 in reset, advances once per enabled cycle
  always_ff @(posedge clk) begin
    if (cpu_rst) cpu_pc <= '0;
    else if (cpu_en) cpu_pc <= cpu_pc + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = OpLoad;
    cmd_data   = '0;
    cpu_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sys_rst = 1'b0;
  endtask

  // Offer one command from a negedge; returns at posedge+1 of the accepting edge
  task automatic send(input logic [1:0] op, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int writes;
    int en_cnt;
    int n;

    // 1: reset values and a single word load
    do_reset();
    check("rst_state", state, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_cyc_cnt", cyc_cnt, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_ld_ovf", ld_ovf, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    send(OpLoad, 16'h1234);
    check("t1_hi_no_we", imem_we, 0);
    send(OpLoad, 16'h5678);
    check("t1_we", imem_we, 1);
    check("t1_addr", imem_addr, 0);
    check("t1_wdata", imem_wdata, 32'h12345678);
    check("t1_cpu_rst", cpu_rst, 1);
    check("t1_state", state, 0);
    @(posedge clk); #1;
    check("t1_we_pulse", imem_we, 0);

    // 2: overflow past 16 words; RUN clears ld_ovf
    do_reset();
    writes = 0;
    for (int i = 0; i < 17; i++) begin
      send(OpLoad, 16'(i));
      send(OpLoad, 16'hA000 + 16'(i));
      if (imem_we) writes++;
      if (i < 16) begin
        check("t2_we", imem_we, 1);
        check("t2_addr", imem_addr, i);
        check("t2_ovf_low", ld_ovf, 0);
      end else begin
        check("t2_we_ovf", imem_we, 0);
      end
    end
    check("t2_writes", writes, 16);
    check("t2_ovf", ld_ovf, 1);
    send(OpRun, 16'h0);
    check("t2_ovf_clr", ld_ovf, 0);
    check("t2_run_state", state, 1);
    check("t2_run_cpu_rst", cpu_rst, 0);
    check("t2_run_cpu_en", cpu_en, 1);

    // 3: run 10 cycles, then core halts; STEP in DONE is an error
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_en) en_cnt++;
      @(posedge clk); #1;
    end
    check("t3_cyc10", cyc_cnt, 10);
    cpu_halted = 1'b1;
    if (cpu_en) en_cnt++;
    @(posedge clk); #1;
    cpu_halted = 1'b0;
    check("t3_state_done", state, 4);
    check("t3_cpu_en_off", cpu_en, 0);
    check("t3_cyc_vs_en", cyc_cnt, en_cnt);
    check("t3_cyc11", cyc_cnt, 11);
    check("t3_no_err", cmd_err, 0);
    send(OpStep, 16'h0);
    check("t3_err", cmd_err, 1);
    check("t3_still_done", state, 4);

    // 4: single step, then RUN and HALT
    do_reset();
    send(OpStep, 16'h0);
    check("t4_step_state", state, 2);
    check("t4_step_en", cpu_en, 1);
    check("t4_step_ready", cmd_ready, 0);
    check("t4_step_cpu_rst", cpu_rst, 0);
    @(posedge clk); #1;
    check("t4_pause", state, 3);
    check("t4_pause_en", cpu_en, 0);
    check("t4_cyc1", cyc_cnt, 1);
    send(OpRun, 16'h0);
    check("t4_run", state, 1);
    @(posedge clk); #1;
    send(OpHalt, 16'h0);
    check("t4_halt_state", state, 3);
    check("t4_halt_en", cpu_en, 0);
    check("t4_cyc3", cyc_cnt, 3);

    // 5: core halt beats HALT command; LOAD in RUN errors; reset mid-run and mid-load
    do_reset();
    send(OpRun, 16'h0);
    cpu_halted = 1'b1;
    send(OpHalt, 16'h0);
    cpu_halted = 1'b0;
    check("t5_done", state, 4);
    check("t5_no_err", cmd_err, 0);
    send(OpLoad, 16'h0);
    check("t5_load_idle", state, 0);
    send(OpRun, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    send(OpLoad, 16'h1111);
    check("t5_load_in_run_err", cmd_err, 1);
    check("t5_load_in_run_state", state, 1);
    check("t5_cyc_nonzero", cyc_cnt != 0, 1);
    @(negedge clk);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    check("t5_rst_state", state, 0);
    check("t5_rst_cpu_rst", cpu_rst, 1);
    check("t5_rst_cpu_en", cpu_en, 0);
    check("t5_rst_cyc", cyc_cnt, 0);
    check("t5_rst_err", cmd_err, 0);
    send(OpLoad, 16'hDEAD);
    do_reset();
    send(OpLoad, 16'hAAAA);
    check("t5_abort_no_we", imem_we, 0);
    send(OpLoad, 16'hBBBB);
    check("t5_abort_we", imem_we, 1);
    check("t5_abort_addr", imem_addr, 0);
    check("t5_abort_wdata", imem_wdata, 32'hAAAABBBB);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // 6: breakpoint at PC 5, then resume past it
    do_reset();
    bp_en   = 1'b1;
    bp_addr = 4'd5;
    send(OpRun, 16'h0);
    n = 0;
    while (state != 3'd3 && n < 20) begin
      if (state == 3'd1 && cpu_pc == 4'd5) check("t6_gate", cpu_en, 0);
      @(posedge clk); #1;
      n++;
    end
    check("t6_pause", state, 3);
    check("t6_bp_hit", bp_hit, 1);
    check("t6_pc", cpu_pc, 5);
    check("t6_cyc", cyc_cnt, 5);
    send(OpRun, 16'h0);
    check("t6_hit_clr", bp_hit, 0);
    check("t6_resume_en", cpu_en, 1);
    @(posedge clk); #1;
    check("t6_pc_past", cpu_pc, 6);
    check("t6_still_run", state, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
